event_blinker: RTL

- Output-side counterpart of the button debouncer. The debouncer turns a noisy human input into a one-cycle pulse; this block turns one-cycle event pulses into human-visible LED blinks.
- Each accepted event produces exactly one blink: LED on for ON_TICKS cycles, then off for OFF_TICKS cycles.
- Events arriving while a blink is in progress are queued in a saturating pending counter. Queue overflow is flagged with a sticky bit.
- Sits between internal event sources (e.g. the debouncer's btn_pressed) and the board LED pins.

---
 rtl/event_blinker.sv | 89 ++++++++
 1 files changed

// File: rtl/event_blinker.sv
// event_blinker: turns one-cycle event pulses into visible LED blinks,
// queueing events that arrive mid-blink in a saturating pending counter.
module event_blinker #(
    parameter int CNT_W     = 16,
    parameter int ON_TICKS  = 50000,
    parameter int OFF_TICKS = 50000,
    parameter int PEND_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              evt_in,
    input  logic              clr,
    output logic              led_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);
    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_TICKS - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_TICKS - 1);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   timer, timer_nx;
    logic [PEND_W-1:0]  pending_nx;
    logic               deq, full, has_pend;

    assign has_pend = pending != '0;
    assign full     = &pending;
    assign busy     = state != IDLE || has_pend;

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        deq      = 1'b0;
        case (state)
            IDLE: if (has_pend) begin
                state_nx = ON;
                timer_nx = ON_LOAD;
                deq      = 1'b1;
            end
            ON: if (timer == '0) begin
                state_nx = OFF;
                timer_nx = OFF_LOAD;
            end else begin
                timer_nx = timer - CNT_W'(1);
            end
            OFF: if (timer != '0) begin
                timer_nx = timer - CNT_W'(1);
            end else if (has_pend) begin
                state_nx = ON;
                timer_nx = ON_LOAD;
                deq      = 1'b1;
            end else begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                timer_nx = '0;
            end
        endcase
    end

    // A saturated counter holds its value; an event is only lost when nothing dequeues.
    assign pending_nx = (evt_in && !deq) ? (full ? pending : pending + PEND_W'(1))
                      : (!evt_in && deq) ? pending - PEND_W'(1) : pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            timer    <= '0;
            pending  <= '0;
            led_out  <= 1'b0;
            overflow <= 1'b0;
        end else if (clr) begin
            state    <= IDLE;
            timer    <= '0;
            pending  <= '0;
            led_out  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nx;
            timer    <= timer_nx;
            pending  <= pending_nx;
            led_out  <= state_nx == ON;
            overflow <= overflow | (evt_in & full & ~deq);
        end
    end
endmodule
